// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default bus widths and the program loader state encoding.
package cpu_pkg;

   localparam int CPU_DATA_W = 16;
   localparam int CPU_ADDR_W = 16;

   typedef enum logic [2:0] {
      LD_IDLE,
      LD_LEN,
      LD_LOAD,
      LD_VERIFY,
      LD_CHECK,
      LD_DONE,
      LD_ERR
   } ld_state_t;

endpackage

// File: rtl/ld_rd_pipe.sv
// Read-return tracker: a RD_LAT-deep shift of read strobes that marks the
// cycle in which mem_rdata belongs to an issued verify read.
module ld_rd_pipe #(
   parameter int RD_LAT = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   input  logic issue,
   output logic ret_valid
);

   logic vld_reg [RD_LAT];

   generate
      for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            // First stage captures the strobe of the read issued this cycle.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n)     vld_reg[gi] <= 1'b0;
               else if (flush) vld_reg[gi] <= 1'b0;
               else            vld_reg[gi] <= issue;
            end
         end else begin : g_next
            // Later stages age the strobe by one memory cycle each.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n)     vld_reg[gi] <= 1'b0;
               else if (flush) vld_reg[gi] <= 1'b0;
               else            vld_reg[gi] <= vld_reg[gi-1];
            end
         end
      end
   endgenerate

   assign ret_valid = vld_reg[RD_LAT-1];

endmodule

// File: rtl/prog_mem_loader.sv
// Stream-driven program memory loader: header (base, count) then payload,
// optional readback checksum, then releases the CPU with a start pulse.
module prog_mem_loader
   import cpu_pkg::*;
#(
   parameter int DATA_W = CPU_DATA_W,
   parameter int ADDR_W = CPU_ADDR_W,
   parameter int RD_LAT = 1,
   parameter int VERIFY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              cpu_hold,
   output logic              start,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [DATA_W-1:0] sum
);

   ld_state_t         state_reg, state_next;
   logic [ADDR_W-1:0] base_reg, base_next;
   logic [DATA_W-1:0] count_reg, count_next;
   logic [DATA_W-1:0] ptr_reg, ptr_next;
   logic [DATA_W-1:0] rptr_reg, rptr_next;
   logic [DATA_W-1:0] rcnt_reg, rcnt_next;
   logic [DATA_W-1:0] sum_reg, sum_next;
   logic [DATA_W-1:0] rsum_reg, rsum_next;
   logic              done_reg, done_next;
   logic              error_reg, error_next;
   logic              cpu_hold_reg, cpu_hold_next;
   logic              start_reg, start_next;
   logic              mem_we_reg, mem_we_next;
   logic              mem_re_reg, mem_re_next;
   logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
   logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
   logic              accept;
   logic              rd_ret;

   // Stream is stalled only while memory is being read back and compared.
   assign in_ready = (state_reg != LD_VERIFY) && (state_reg != LD_CHECK);
   assign accept   = in_valid && in_ready;

   ld_rd_pipe #(
      .RD_LAT(RD_LAT)
   ) u_rd_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (abort),
      .issue    (mem_re_reg),
      .ret_valid(rd_ret)
   );

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= LD_IDLE;
         base_reg      <= '0;
         count_reg     <= '0;
         ptr_reg       <= '0;
         rptr_reg      <= '0;
         rcnt_reg      <= '0;
         sum_reg       <= '0;
         rsum_reg      <= '0;
         done_reg      <= 1'b0;
         error_reg     <= 1'b0;
         cpu_hold_reg  <= 1'b0;
         start_reg     <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_re_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
      end else begin
         state_reg     <= state_next;
         base_reg      <= base_next;
         count_reg     <= count_next;
         ptr_reg       <= ptr_next;
         rptr_reg      <= rptr_next;
         rcnt_reg      <= rcnt_next;
         sum_reg       <= sum_next;
         rsum_reg      <= rsum_next;
         done_reg      <= done_next;
         error_reg     <= error_next;
         cpu_hold_reg  <= cpu_hold_next;
         start_reg     <= start_next;
         mem_we_reg    <= mem_we_next;
         mem_re_reg    <= mem_re_next;
         mem_addr_reg  <= mem_addr_next;
         mem_wdata_reg <= mem_wdata_next;
      end
   end

   // Next-state logic; strobes and start default low so each lasts one cycle.
   always_comb begin
      state_next     = state_reg;
      base_next      = base_reg;
      count_next     = count_reg;
      ptr_next       = ptr_reg;
      rptr_next      = rptr_reg;
      rcnt_next      = rcnt_reg;
      sum_next       = sum_reg;
      rsum_next      = rsum_reg;
      done_next      = done_reg;
      error_next     = error_reg;
      cpu_hold_next  = cpu_hold_reg;
      start_next     = 1'b0;
      mem_we_next    = 1'b0;
      mem_re_next    = 1'b0;
      mem_addr_next  = mem_addr_reg;
      mem_wdata_next = mem_wdata_reg;

      if (abort) begin
         state_next    = LD_IDLE;
         cpu_hold_next = 1'b0;
      end else begin
         case (state_reg)
            LD_IDLE, LD_DONE, LD_ERR: begin
               if (accept) begin
                  base_next     = in_data[ADDR_W-1:0];
                  done_next     = 1'b0;
                  error_next    = 1'b0;
                  sum_next      = '0;
                  cpu_hold_next = 1'b1;
                  state_next    = LD_LEN;
               end
            end
            LD_LEN: begin
               if (accept) begin
                  count_next = in_data;
                  ptr_next   = '0;
                  if (in_data == '0) begin
                     state_next    = LD_DONE;
                     done_next     = 1'b1;
                     cpu_hold_next = 1'b0;
                     start_next    = 1'b1;
                  end else begin
                     state_next = LD_LOAD;
                  end
               end
            end
            LD_LOAD: begin
               if (accept) begin
                  mem_we_next    = 1'b1;
                  mem_addr_next  = base_reg + ptr_reg[ADDR_W-1:0];
                  mem_wdata_next = in_data;
                  sum_next       = sum_reg + in_data;
                  ptr_next       = ptr_reg + 1'b1;
                  if (ptr_reg == count_reg - 1'b1) begin
                     if (VERIFY != 0) begin
                        state_next = LD_VERIFY;
                        rptr_next  = '0;
                        rcnt_next  = '0;
                        rsum_next  = '0;
                     end else begin
                        state_next    = LD_DONE;
                        done_next     = 1'b1;
                        cpu_hold_next = 1'b0;
                        start_next    = 1'b1;
                     end
                  end
               end
            end
            LD_VERIFY: begin
               // Issue side: one read per cycle until count reads are out.
               if (rptr_reg != count_reg) begin
                  mem_re_next   = 1'b1;
                  mem_addr_next = base_reg + rptr_reg[ADDR_W-1:0];
                  rptr_next     = rptr_reg + 1'b1;
               end
               // Return side: accumulate tagged data, leave on the last one.
               if (rd_ret) begin
                  rsum_next = rsum_reg + mem_rdata;
                  rcnt_next = rcnt_reg + 1'b1;
                  if (rcnt_reg == count_reg - 1'b1) begin
                     state_next = LD_CHECK;
                  end
               end
            end
            LD_CHECK: begin
               if (rsum_reg == sum_reg) begin
                  state_next    = LD_DONE;
                  done_next     = 1'b1;
                  cpu_hold_next = 1'b0;
                  start_next    = 1'b1;
               end else begin
                  state_next = LD_ERR;
                  error_next = 1'b1;
               end
            end
            default: begin
               state_next = LD_IDLE;
            end
         endcase
      end
   end

   assign mem_we    = mem_we_reg;
   assign mem_re    = mem_re_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;
   assign cpu_hold  = cpu_hold_reg;
   assign start     = start_reg;
   assign done      = done_reg;
   assign error     = error_reg;
   assign sum       = sum_reg;
   assign busy      = (state_reg == LD_LEN) || (state_reg == LD_LOAD) ||
                      (state_reg == LD_VERIFY) || (state_reg == LD_CHECK);

endmodule

// File: tb/tb_prog_mem_loader.sv
// Bench for prog_mem_loader: scoreboarded writes against an ideal memory
// with a three-cycle read latency and an optional corrupted location.
module tb_prog_mem_loader;

   localparam int LAT = 3;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] d;
      logic [31:0] c;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        abort = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_ready, mem_we, mem_re, cpu_hold, start, busy, done, error;
   logic [15:0] mem_addr, mem_wdata, mem_rdata, sum;

   logic [15:0] mem [0:65535];
   logic [15:0] rd_pipe [LAT];
   logic        corrupt = 1'b0;

   wr_t         exp_q[$];
   wr_t         obs_q[$];
   logic [15:0] pay[$];
   int          checks = 0, errors = 0;
   int          cyc = 0, rd_cnt = 0, start_cnt = 0, start_cyc = -1, overlap = 0;
   int          acc_cyc = 0, len_cyc = 0;

   always #5 clk = ~clk;

   prog_mem_loader #(
      .DATA_W(16),
      .ADDR_W(16),
      .RD_LAT(LAT),
      .VERIFY(1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .abort    (abort),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .mem_we   (mem_we),
      .mem_re   (mem_re),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .cpu_hold (cpu_hold),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .error    (error),
      .sum      (sum)
   );

   // Memory model: synchronous write, LAT-cycle read pipeline.
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      rd_pipe[0] <= (corrupt && mem_addr == 16'h0029) ? 16'h0000 : mem[mem_addr];
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_rdata = rd_pipe[LAT-1];

   // Monitor on the falling edge: record writes, reads and start pulses.
   always @(negedge clk) begin
      if (mem_we) obs_q.push_back({mem_addr, mem_wdata, 32'(cyc)});
      if (mem_re) rd_cnt++;
      if (mem_we && mem_re) overlap++;
      if (start) begin
         start_cnt++;
         start_cyc = cyc;
      end
      cyc++;
   end

   task automatic clear_sb();
      exp_q.delete();
      obs_q.delete();
      rd_cnt = 0;
      start_cnt = 0;
      start_cyc = -1;
   endtask

   task automatic send(input logic [15:0] d);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) begin
         checks++; errors++;
         $display("FAIL send_timeout: in_ready stayed 0, required 1");
      end
      @(posedge clk);
      acc_cyc = cyc;
      #1;
      in_valid = 1'b0;
   endtask

   // Header, then min(cnt, pay.size()) payload words; expected writes queued.
   task automatic drive_load(input logic [15:0] base, input logic [15:0] cnt, input int gap);
      logic [15:0] a;
      send(base);
      send(cnt);
      len_cyc = acc_cyc;
      for (int i = 0; i < pay.size() && i < int'(cnt); i++) begin
         send(pay[i]);
         a = base + 16'(i);
         exp_q.push_back({a, pay[i], 32'(acc_cyc)});
         repeat (gap) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic wait_end(input logic [15:0] base);
      int n = 0;
      while (!(done || error) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 300) begin
         checks++; errors++;
         $display("FAIL end_timeout: done/error stayed 0, required one of them 1");
      end
      repeat (3) begin
         @(posedge clk); #1;
      end
      $display("load base=%h words=%0d sum=%h reads=%0d starts=%0d done=%b error=%b",
               base, pay.size(), sum, rd_cnt, start_cnt, done, error);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, mem_we, mem_re, cpu_hold, start, busy, done, error} !== 8'b1000_0000) begin
         errors++;
         $display("FAIL reset_flags: got %b, required 10000000",
                  {in_ready, mem_we, mem_re, cpu_hold, start, busy, done, error});
      end
      checks++;
      if ({sum, mem_addr, mem_wdata} !== 48'h0) begin
         errors++;
         $display("FAIL reset_regs: got sum %h addr %h wdata %h, required all 0", sum, mem_addr, mem_wdata);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      wr_t e, o;
      clear_sb();
      pay = '{16'h0007, 16'h0008, 16'h0009};
      drive_load(16'h0028, 16'h0003, 0);
      checks++;
      if ({cpu_hold, busy, in_ready} !== 3'b110) begin
         errors++;
         $display("FAIL basic_verify_state: got hold/busy/ready %b, required 110", {cpu_hold, busy, in_ready});
      end
      wait_end(16'h0028);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL basic_write: missing, required addr %h data %h", e.a, e.d);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               errors++;
               $display("FAIL basic_write: got addr %h data %h cyc %0d, required addr %h data %h cyc %0d",
                        o.a, o.d, o.c, e.a, e.d, e.c);
            end
         end
      end
      checks++;
      if (sum !== 16'h0018) begin errors++; $display("FAIL basic_sum: got %h, required 0018", sum); end
      checks++;
      if (rd_cnt != 3) begin errors++; $display("FAIL basic_reads: got %0d, required 3", rd_cnt); end
      checks++;
      if ({done, error, cpu_hold} !== 3'b100) begin
         errors++;
         $display("FAIL basic_flags: got done/error/hold %b, required 100", {done, error, cpu_hold});
      end
      checks++;
      if (start_cnt != 1) begin errors++; $display("FAIL basic_start: got %0d pulses, required 1", start_cnt); end
      checks++;
      if (mem[16'h0029] !== 16'h0008) begin errors++; $display("FAIL basic_mem: got %h, required 0008", mem[16'h0029]); end
   endtask

   task automatic test_zero_count();
      clear_sb();
      pay.delete();
      drive_load(16'h0010, 16'h0000, 0);
      wait_end(16'h0010);
      checks++;
      if (obs_q.size() != 0 || rd_cnt != 0) begin
         errors++;
         $display("FAIL zero_access: got %0d writes %0d reads, required 0 0", obs_q.size(), rd_cnt);
      end
      checks++;
      if (start_cnt != 1 || start_cyc != len_cyc) begin
         errors++;
         $display("FAIL zero_start: got %0d pulses at cycle %0d, required 1 at cycle %0d", start_cnt, start_cyc, len_cyc);
      end
      checks++;
      if ({done, cpu_hold} !== 2'b10 || sum !== 16'h0) begin
         errors++;
         $display("FAIL zero_flags: got done/hold %b sum %h, required 10 sum 0000", {done, cpu_hold}, sum);
      end
   endtask

   task automatic test_wrap();
      wr_t e, o;
      clear_sb();
      pay = '{16'hAAAA, 16'h5555};
      drive_load(16'hFFFF, 16'h0002, 0);
      wait_end(16'hFFFF);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL wrap_write: missing, required addr %h data %h", e.a, e.d);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               errors++;
               $display("FAIL wrap_write: got addr %h data %h, required addr %h data %h", o.a, o.d, e.a, e.d);
            end
         end
      end
      checks++;
      if (sum !== 16'hFFFF || done !== 1'b1) begin
         errors++;
         $display("FAIL wrap_result: got sum %h done %b, required FFFF 1", sum, done);
      end
   endtask

   task automatic test_corrupt();
      clear_sb();
      corrupt = 1'b1;
      pay = '{16'h0007, 16'h0008, 16'h0009};
      drive_load(16'h0028, 16'h0003, 0);
      wait_end(16'h0028);
      corrupt = 1'b0;
      checks++;
      if ({error, done, cpu_hold} !== 3'b101) begin
         errors++;
         $display("FAIL corrupt_flags: got error/done/hold %b, required 101", {error, done, cpu_hold});
      end
      checks++;
      if (start_cnt != 0 || rd_cnt != 3) begin
         errors++;
         $display("FAIL corrupt_counts: got %0d starts %0d reads, required 0 3", start_cnt, rd_cnt);
      end
   endtask

   task automatic test_bubbles();
      wr_t e, o;
      clear_sb();
      pay = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      drive_load(16'h0100, 16'h0004, 1);
      wait_end(16'h0100);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL bubble_write: missing, required addr %h data %h", e.a, e.d);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               errors++;
               $display("FAIL bubble_write: got addr %h data %h cyc %0d, required addr %h data %h cyc %0d",
                        o.a, o.d, o.c, e.a, e.d, e.c);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("FAIL bubble_extra: got %0d extra writes, required 0", obs_q.size()); end
      checks++;
      if (sum !== 16'hAAAA || done !== 1'b1 || start_cnt != 1) begin
         errors++;
         $display("FAIL bubble_result: got sum %h done %b starts %0d, required AAAA 1 1", sum, done, start_cnt);
      end
   endtask

   task automatic test_abort();
      clear_sb();
      pay = '{16'hBEEF};
      drive_load(16'h0040, 16'h0003, 0);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      checks++;
      if ({in_ready, busy, cpu_hold, done, error} !== 5'b10000) begin
         errors++;
         $display("FAIL abort_state: got ready/busy/hold/done/error %b, required 10000",
                  {in_ready, busy, cpu_hold, done, error});
      end
      repeat (4) begin @(posedge clk); #1; end
      checks++;
      if (start_cnt != 0 || obs_q.size() != 1) begin
         errors++;
         $display("FAIL abort_activity: got %0d starts %0d writes, required 0 1", start_cnt, obs_q.size());
      end
      clear_sb();
      pay = '{16'h0001, 16'h0002};
      drive_load(16'h0050, 16'h0002, 0);
      wait_end(16'h0050);
      checks++;
      if (sum !== 16'h0003 || done !== 1'b1 || start_cnt != 1) begin
         errors++;
         $display("FAIL abort_reload: got sum %h done %b starts %0d, required 0003 1 1", sum, done, start_cnt);
      end
   endtask

   task automatic test_reset_mid_verify();
      clear_sb();
      pay = '{16'h0005, 16'h0006, 16'h0007, 16'h0008};
      drive_load(16'h0060, 16'h0004, 0);
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, busy, cpu_hold, start, mem_re} !== 5'b10000 || sum !== 16'h0) begin
         errors++;
         $display("FAIL rst_verify_state: got ready/busy/hold/start/re %b sum %h, required 10000 0000",
                  {in_ready, busy, cpu_hold, start, mem_re}, sum);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
      checks++;
      if (start_cnt != 0) begin errors++; $display("FAIL rst_verify_start: got %0d, required 0", start_cnt); end
      clear_sb();
      pay = '{16'h0009, 16'h000A};
      drive_load(16'h0070, 16'h0002, 0);
      wait_end(16'h0070);
      checks++;
      if (sum !== 16'h0013 || done !== 1'b1 || rd_cnt != 2 || start_cnt != 1) begin
         errors++;
         $display("FAIL rst_reload: got sum %h done %b reads %0d starts %0d, required 0013 1 2 1",
                  sum, done, rd_cnt, start_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_count();
      test_wrap();
      test_corrupt();
      test_bubbles();
      test_abort();
      test_reset_mid_verify();
      checks++;
      if (overlap != 0) begin errors++; $display("FAIL we_re_overlap: got %0d cycles, required 0", overlap); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
